// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   state_t         receiver FSM states
//   DEF_DATA_BITS   default data bits per frame
//   DEF_OVERSAMPLE  default baud_tick pulses per bit period
//   IDLE_LEVEL      level of an idle serial line
//   majority3()     2-of-3 vote used for bit decisions
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int   DEF_DATA_BITS  = 8;
  localparam int   DEF_OVERSAMPLE = 16;
  localparam logic IDLE_LEVEL     = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset; both flops load RESET_VAL
//   d      asynchronous input
//   q      synchronized output, two clk edges behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: both flops reset to the line's resting level so that leaving reset
  // never looks like an edge on the synchronized signal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 1 start bit, DATA_BITS data bits
// LSB first, 1 stop bit. Each bit is a 2-of-3 vote around its midpoint.
//   clk        single clock, rising edge
//   reset      asynchronous active-low reset
//   baud_tick  one-clk strobe at OVERSAMPLE x baud rate
//   rx         asynchronous serial line, idles high
//   data       last good byte, held until the next good frame
//   valid      one-clk pulse, data is new
//   frame_err  one-clk pulse, stop bit was sampled low
//   busy       high whenever the FSM is not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] C_LO   = CW'(M - 1);
  localparam logic [CW-1:0] C_MID  = CW'(M);
  localparam logic [CW-1:0] C_HI   = CW'(M + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 s0, s1;
  logic                 bit_val;
  logic                 decide;
  logic                 wrap;

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // The vote uses the two stored samples plus the live sample on tick M+1.
  assign bit_val = majority3(s0, s1, rx_s);
  assign decide  = (cnt == C_HI);
  assign wrap    = (cnt == C_LAST);

  // NOTE: every register here is sequential state, so it is updated with
  // non-blocking assignments only; pulses default low each clk so they stay
  // exactly one clk wide whatever the baud_tick spacing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          BREAK: begin
            // Line must be seen high again before a new start can be hunted.
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (cnt == C_LO)  s0 <= rx_s;
            if (cnt == C_MID) s1 <= rx_s;
            case (state)
              START: begin
                if (decide && bit_val) begin
                  // False start: the line went back high before mid-bit.
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                end else if (wrap) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end
              end
              DATA: begin
                if (decide) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                if (wrap) begin
                  if (bit_cnt == B_LAST) state <= STOP;
                  else                   bit_cnt <= bit_cnt + BW'(1);
                end
              end
              STOP: begin
                // Finish at the stop midpoint so a following start edge can
                // arrive as early as the very next tick.
                if (decide) begin
                  cnt <= '0;
                  if (bit_val) begin
                    data  <= shreg;
                    valid <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                  end else begin
                    frame_err <= 1'b1;
                    state     <= BREAK;
                  end
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard-driven bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16,
// baud_tick every 4 clk).
module tb_uart_rx;

  localparam int OS = 16;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int   n_cmp = 0;
  int   n_mis = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  exp_t exp_q[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // baud_tick: one clk high out of every four, changed on the falling edge.
  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every output pulse pops one expected event.
  always @(negedge clk) begin
    exp_t e;
    if (valid && frame_err) begin
      n_cmp++; n_mis++;
      $display("FAIL pulse_overlap: valid and frame_err both high, required at most one");
    end
    if (valid || frame_err) begin
      if (valid) valid_cnt++;
      if (frame_err) err_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=%h, required no pulse",
                 valid, frame_err, data);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.is_err || data !== e.data) begin
          n_mis++;
          $display("FAIL scoreboard: frame_err=%b data=%h, required frame_err=%b data=%h",
                   frame_err, data, e.is_err, e.data);
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // glitch[i] inverts data bit i for one tick at the receiver's cnt=M sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int stop_ticks, input logic [7:0] glitch);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (glitch[i]) begin
        wait_ticks(OS / 2 + 1);
        rx = ~b[i];
        wait_ticks(1);
        rx = b[i];
        wait_ticks(OS / 2 - 2);
      end else begin
        wait_ticks(OS);
      end
    end
    rx = stop_v;
    wait_ticks(stop_ticks);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_mis++;
      $display("FAIL %s_drained: %0d expected events left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_byte("reset_data", data, 8'h00);
    check_bit("reset_valid", valid, 1'b0);
    check_bit("reset_frame_err", frame_err, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    reset = 1'b1;
    wait_ticks(4);
    check_bit("idle_busy", busy, 1'b0);
  endtask

  task automatic test_normal();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    push(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, OS, 8'h00);
    wait_ticks(4);
    check_drained("normal");
    check_int("normal_valid_pulses", valid_cnt - v0, 1);
    check_int("normal_frame_err_pulses", err_cnt - e0, 0);
    check_byte("normal_data", data, 8'hA5);
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    rx = 1'b0;
    wait_ticks(3);
    check_bit("glitch_busy_during", busy, 1'b1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(8);
    check_bit("glitch_busy_after", busy, 1'b0);
    check_int("glitch_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    check_byte("glitch_data_held", data, 8'hA5);
  endtask

  task automatic test_frame_err();
    int e0 = err_cnt;
    push(1'b1, 8'hA5);
    send_frame(8'h3C, 1'b0, 40, 8'h00);
    check_int("ferr_pulses", err_cnt - e0, 1);
    check_bit("ferr_busy_held", busy, 1'b1);
    check_byte("ferr_data_kept", data, 8'hA5);
    rx = 1'b1;
    wait_ticks(2);
    check_bit("ferr_busy_release", busy, 1'b0);
    push(1'b0, 8'h55);
    send_frame(8'h55, 1'b1, OS, 8'h00);
    wait_ticks(4);
    check_drained("ferr");
    check_byte("ferr_next_data", data, 8'h55);
  endtask

  task automatic test_noise();
    push(1'b0, 8'h0F);
    send_frame(8'h0F, 1'b1, OS, 8'hFF);
    wait_ticks(4);
    check_drained("noise");
    check_byte("noise_data", data, 8'h0F);
  endtask

  task automatic test_reset_midframe();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    rx = 1'b0;
    wait_ticks(OS);
    rx = 1'b1;
    wait_ticks(3 * OS + OS / 2);
    check_bit("midrst_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("midrst_busy", busy, 1'b0);
    check_byte("midrst_data", data, 8'h00);
    check_bit("midrst_valid", valid, 1'b0);
    wait_ticks(4);
    reset = 1'b1;
    wait_ticks(OS * 6);
    check_int("midrst_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    check_bit("midrst_idle", busy, 1'b0);
    push(1'b0, 8'h81);
    send_frame(8'h81, 1'b1, OS, 8'h00);
    wait_ticks(4);
    check_drained("midrst");
    check_byte("midrst_next_data", data, 8'h81);
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    push(1'b0, 8'h01);
    push(1'b0, 8'hFE);
    // Stop held only to just past its midpoint before the next start edge.
    send_frame(8'h01, 1'b1, OS / 2 + 4, 8'h00);
    send_frame(8'hFE, 1'b1, OS, 8'h00);
    wait_ticks(4);
    check_drained("b2b");
    check_int("b2b_valid_pulses", valid_cnt - v0, 2);
    check_byte("b2b_last_data", data, 8'hFE);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_glitch();
    test_frame_err();
    test_noise();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16: baud_tick pulses per bit period; legal values are even numbers 8 or greater.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 baud_tick  input  1  one-clk-wide strobe at OVERSAMPLE x baud rate, driven by the team's clock divider.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 data  output  DATA_BITS  last received byte; held until the next successful frame.
REQ-008 valid  output  1  one-clk pulse; data is new.
REQ-009 frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; the synchronized value is rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-013 A tick counter cnt (0..OVERSAMPLE-1) SHALL advance only on baud_tick and wrap to 0 at the end of each bit period.
REQ-014 Each bit value SHALL be the 2-of-3 majority of rx_s sampled on ticks cnt=M-1, M and M+1, where M=OVERSAMPLE/2; the decision is made on tick cnt=M+1.
REQ-015 IDLE: on a baud_tick with rx_s=0, the FSM SHALL go to START with cnt=0.
REQ-016 START: if the majority at cnt=M+1 is 1 (false start), the FSM SHALL return to IDLE with no output pulse; otherwise it SHALL go to DATA at the wrap of cnt.
REQ-017 DATA: the FSM SHALL shift the majority bit into a shift register at cnt=M+1, LSB first, and count bits 0..DATA_BITS-1.
REQ-018 DATA: after the last bit wraps, the FSM SHALL go to STOP.
REQ-019 STOP with majority 1 at cnt=M+1: data SHALL load the shift register, valid SHALL pulse on the next clk edge, and the FSM SHALL go to IDLE without waiting for the full stop period.
REQ-020 STOP with majority 0 at cnt=M+1: frame_err SHALL pulse, data SHALL remain unchanged, and the FSM SHALL go to BREAK.
REQ-021 BREAK: the FSM SHALL stay until a baud_tick with rx_s=1, then go to IDLE.
REQ-022 valid and frame_err SHALL never be asserted in the same cycle.
REQ-023 Each of valid and frame_err SHALL be exactly one clk wide, regardless of the baud_tick spacing.
REQ-024 Line activity without baud_tick SHALL cause no state change other than the synchronizer shift.
REQ-025 Back-to-back frames SHALL be received when a start edge follows the stop-bit midpoint by any number of ticks 0 or greater.

Reset
REQ-026 While reset=0, all state SHALL clear asynchronously: FSM=IDLE, cnt=0, bit counter=0, shift register=0, data=0, valid=0, frame_err=0, busy=0, and synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse.
REQ-028 After reset release, the first frame SHALL be received only from a fresh start edge.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state enum, default DATA_BITS/OVERSAMPLE constants, and the idle line level.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named sync_2ff (async active-low reset, reset value parameterized), reusable by other UART blocks.
REQ-031 The remaining logic SHALL be a single FSM with counters in uart_rx; the expected RTL size is about 150-250 lines.

Verification
REQ-032 Normal frame, baud_tick every 4 clk, byte 0xA5 sent with 1 stop bit -> exactly one valid pulse, data=0xA5, frame_err never high.
REQ-033 Glitch: rx low for 5 ticks then high -> no output pulse, busy falls back to 0 after tick cnt=M+1.
REQ-034 Framing error: byte 0x3C sent with stop bit low, rx then held low for 40 ticks and released -> one frame_err pulse; data keeps the previous value; busy stays 1 until rx_s=1 is seen on a tick; the next 0x55 is received correctly.
REQ-035 Noise: one-tick inverted glitch at cnt=M on each data bit of 0x0F -> data=0x0F through the majority vote.
REQ-036 Reset: reset asserted during data bit 3 of 0xFF -> outputs clear immediately; no pulse; the following 0x81 is received correctly.
REQ-037 Back-to-back: 0x01 then 0xFE with the start edge immediately after the stop midpoint -> two valid pulses, data 0x01 then 0xFE.
